// File: rtl/stw_defs_pkg.sv
// Shared stopwatch definitions: FSM state codes and default timing constants.
package stw_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } stw_state_e;

  localparam int DEF_LONG_PRESS_CYC = 100;
  localparam int DEF_LAP_HOLD_CYC   = 300;

endpackage

// File: rtl/stw_edge_det.sv
// Rising-edge detector for a debounced button level.
// The pulse is registered, so it lands one edge after the level is first sampled.
module stw_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/stw_lap_ctrl.sv
// Stopwatch mode controller: start/stop and lap/reset buttons -> count_en, freeze_en, clear.
// Define STW_LAP_TIMEOUT_EN to auto-release the lap freeze after LAP_HOLD_CYC cycles.
module stw_lap_ctrl
  import stw_defs::*;
#(
  parameter int LONG_PRESS_CYC = DEF_LONG_PRESS_CYC,
  parameter int LAP_HOLD_CYC   = DEF_LAP_HOLD_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic       count_en,
  output logic       freeze_en,
  output logic       clear,
  output logic [1:0] state
);

  localparam int PW = $clog2(LONG_PRESS_CYC);

  stw_state_e    st, nxt;
  logic          rise_start, rise_lap;
  logic          lap_held;
  logic          armed;
  logic [PW-1:0] press_cnt;
  logic          press_step, press_done, go_idle;
  logic          timeout;

  stw_edge_det u_start_ed (.clk(clk), .reset(reset), .level(btn_start), .rise(rise_start));
  stw_edge_det u_lap_ed   (.clk(clk), .reset(reset), .level(btn_lap),   .rise(rise_lap));

  // Lap level delayed to line up with rise_lap, so the press cycle itself counts as held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lap_held <= 1'b0;
    else        lap_held <= btn_lap;
  end

  assign press_step = (st == STOP) && !rise_start && (armed || rise_lap) && lap_held;
  assign press_done = press_step && (press_cnt == PW'(LONG_PRESS_CYC - 1));

`ifdef STW_LAP_TIMEOUT_EN
  localparam int HW = $clog2(LAP_HOLD_CYC);
  logic [HW-1:0] hold_cnt;

  assign timeout = (hold_cnt == HW'(LAP_HOLD_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         hold_cnt <= '0;
    else if (st == LAP && nxt == LAP)   hold_cnt <= hold_cnt + HW'(1);
    else                                hold_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt     = st;
    go_idle = 1'b0;
    case (st)
      IDLE: if (rise_start) nxt = RUN;
      RUN: begin
        if (rise_start)    nxt = STOP;
        else if (rise_lap) nxt = LAP;
      end
      LAP: begin
        if (rise_start)    nxt = STOP;
        else if (rise_lap) nxt = RUN;
        else if (timeout)  nxt = RUN;
      end
      STOP: begin
        if (rise_start) nxt = RUN;
        else if (press_done) begin
          nxt     = IDLE;
          go_idle = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    count_en  = (st == RUN) || (st == LAP);
    freeze_en = (st == LAP);
    state     = st;
  end

  // Long-press tracking: any break in the hold or leaving STOP disarms and zeroes the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      press_cnt <= '0;
    end else if (press_step && !press_done) begin
      armed     <= 1'b1;
      press_cnt <= press_cnt + PW'(1);
    end else begin
      armed     <= 1'b0;
      press_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clear <= 1'b0;
    else        clear <= go_idle;
  end

endmodule

// File: tb/tb_stw_lap_ctrl.sv
// Directed bench for stw_lap_ctrl (LONG_PRESS_CYC=8, LAP_HOLD_CYC=16); honours STW_LAP_TIMEOUT_EN.
module tb_stw_lap_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start;
  logic       btn_lap;
  logic       count_en;
  logic       freeze_en;
  logic       clear;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  stw_lap_ctrl #(.LONG_PRESS_CYC(8), .LAP_HOLD_CYC(16)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .count_en(count_en), .freeze_en(freeze_en), .clear(clear), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press a button for two sampled cycles; state change is visible after the second.
  task automatic press_start();
    btn_start = 1'b1; tick(2); btn_start = 1'b0; tick(1);
  endtask

  task automatic press_lap();
    btn_lap = 1'b1; tick(2); btn_lap = 1'b0; tick(1);
  endtask

  initial begin
    logic bad;
    reset = 1'b0; btn_start = 1'b0; btn_lap = 1'b0;
    #1;
    check("reset_state", {6'd0, state}, 8'd0);
    check("reset_outs", {5'd0, count_en, freeze_en, clear}, 8'd0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // Start from IDLE, held 5 cycles
    btn_start = 1'b1;
    tick(1);
    check("start_lat1", {6'd0, state}, 8'd0);
    tick(1);
    check("start_run", {6'd0, state}, 8'd1);
    check("start_cnt_en", {7'd0, count_en}, 8'd1);
    tick(3);
    btn_start = 1'b0;
    tick(1);
    check("start_hold_once", {6'd0, state}, 8'd1);
    press_start();
    check("stop_state", {6'd0, state}, 8'd2);
    check("stop_cnt_en", {7'd0, count_en}, 8'd0);

    // Async reset mid-RUN
    press_start();
    check("rerun", {6'd0, state}, 8'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", {6'd0, state}, 8'd0);
    check("async_rst_outs", {5'd0, count_en, freeze_en, clear}, 8'd0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // Lap handling
    press_start();
    press_lap();
    check("lap_state", {6'd0, state}, 8'd3);
    check("lap_outs", {6'd0, count_en, freeze_en}, 8'b11);
    press_lap();
    check("lap_release", {6'd0, state}, 8'd1);
    check("lap_rel_frz", {7'd0, freeze_en}, 8'd0);
    press_lap();
    press_start();
    check("lap_to_stop", {6'd0, state}, 8'd2);
    check("lap_stop_frz", {7'd0, freeze_en}, 8'd0);

    // Long press: 7 cycles is too short
    bad = 1'b0;
    btn_lap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (state !== 2'd2 || clear !== 1'b0) bad = 1'b1;
    end
    btn_lap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (state !== 2'd2 || clear !== 1'b0) bad = 1'b1;
    end
    check("short_press", {7'd0, bad}, 8'd0);

    // Long press: 8 cycles clears, holding on gives nothing more
    btn_lap = 1'b1;
    tick(8);
    check("long_pre_state", {6'd0, state}, 8'd2);
    check("long_pre_clr", {7'd0, clear}, 8'd0);
    tick(1);
    check("long_idle", {6'd0, state}, 8'd0);
    check("long_clr", {7'd0, clear}, 8'd1);
    tick(1);
    check("long_clr_once", {7'd0, clear}, 8'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (state !== 2'd0 || clear !== 1'b0) bad = 1'b1;
    end
    check("long_hold_more", {7'd0, bad}, 8'd0);
    btn_lap = 1'b0;
    tick(1);
    press_lap();
    check("idle_ignore_lap", {6'd0, state}, 8'd0);

    // Simultaneous start and lap in RUN
    press_start();
    btn_start = 1'b1; btn_lap = 1'b1;
    tick(1);
    check("simul_frz_mid", {7'd0, freeze_en}, 8'd0);
    tick(1);
    check("simul_state", {6'd0, state}, 8'd2);
    check("simul_frz", {7'd0, freeze_en}, 8'd0);
    btn_start = 1'b0; btn_lap = 1'b0;
    tick(1);

    // LAP persistence / timeout
    press_start();
    btn_lap = 1'b1;
    tick(2);
    check("to_lap_entry", {6'd0, state}, 8'd3);
    btn_lap = 1'b0;
`ifdef STW_LAP_TIMEOUT_EN
    tick(15);
    check("to_still_lap", {6'd0, state}, 8'd3);
    tick(1);
    check("to_run", {6'd0, state}, 8'd1);
    check("to_frz", {7'd0, freeze_en}, 8'd0);
`else
    tick(100);
    check("nto_lap", {6'd0, state}, 8'd3);
    check("nto_frz", {7'd0, freeze_en}, 8'd1);
`endif
    press_start();
    check("final_stop", {6'd0, state}, 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
